// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and shifts
// them out one bit per clock, with a one-word holding register for gap-free streaming.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter logic MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VLD,
    output logic             DIN_RDY,
    output logic             OUT,
    output logic             OUT_VLD,
    output logic             FRAME_START,
    output logic             BUSY,
    output logic             DBG_STATE
);

    // Handshake: a word transfers on any cycle where DIN_VLD && DIN_RDY. DIN_RDY
    // depends only on HOLD_VLD and RST, never on DIN_VLD, and DIN may change freely
    // whenever the transfer condition is false.

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic             hold_vld;
    logic [CW-1:0]    cnt;
    logic             out_q;
    logic             out_vld_q;
    logic             frame_start_q;

    logic             accept;
    logic             load_en;
    logic             drain;
    logic             advance;
    logic             hold_wr;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic second_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-2] : w[1];
    endfunction

    assign DIN_RDY = !hold_vld && !RST;
    assign accept  = DIN_VLD && DIN_RDY;

    // Decide what the shifter does at the next edge: load a new word, advance, or stop.
    always_comb begin
        load_en   = 1'b0;
        drain     = 1'b0;
        advance   = 1'b0;
        hold_wr   = 1'b0;
        load_word = DIN;
        case (state)
            IDLE: begin
                load_en = accept;
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    if (hold_vld) begin
                        load_en   = 1'b1;
                        load_word = hold;
                        drain     = 1'b1;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                    hold_wr = accept;
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            sr            <= '0;
            hold          <= '0;
            hold_vld      <= 1'b0;
            cnt           <= '0;
            out_q         <= IDLE_BIT;
            out_vld_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (load_en) begin
                state         <= SHIFT;
                sr            <= load_word;
                cnt           <= '0;
                out_q         <= first_bit(load_word);
                out_vld_q     <= 1'b1;
                frame_start_q <= 1'b1;
            end else if (advance) begin
                sr            <= shift_once(sr);
                cnt           <= cnt + 1'b1;
                out_q         <= second_bit(sr);
                frame_start_q <= 1'b0;
            end else begin
                state         <= IDLE;
                out_q         <= IDLE_BIT;
                out_vld_q     <= 1'b0;
                frame_start_q <= 1'b0;
            end

            // A drain never coincides with a write because DIN_RDY is low while HOLD is full.
            if (drain) begin
                hold_vld <= 1'b0;
            end else if (hold_wr) begin
                hold     <= DIN;
                hold_vld <= 1'b1;
            end
        end
    end

    assign OUT         = out_q;
    assign OUT_VLD     = out_vld_q;
    assign FRAME_START = frame_start_q;
    assign BUSY        = (state == SHIFT) || hold_vld;
    assign DBG_STATE   = state;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB-first x8, LSB-first x8, LSB-first x4)
// with hand-written expected bit streams pushed on accept and popped by per-DUT monitors.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] din_m, din_l;
    logic [3:0] din_4;
    logic vld_m, vld_l, vld_4;
    logic rdy_m, out_m, ov_m, fs_m, busy_m, st_m;
    logic rdy_l, out_l, ov_l, fs_l, busy_l, st_l;
    logic rdy_4, out_4, ov_4, fs_4, busy_4, st_4;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .CLK(clk), .RST(rst), .DIN(din_m), .DIN_VLD(vld_m), .DIN_RDY(rdy_m),
        .OUT(out_m), .OUT_VLD(ov_m), .FRAME_START(fs_m), .BUSY(busy_m), .DBG_STATE(st_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .CLK(clk), .RST(rst), .DIN(din_l), .DIN_VLD(vld_l), .DIN_RDY(rdy_l),
        .OUT(out_l), .OUT_VLD(ov_l), .FRAME_START(fs_l), .BUSY(busy_l), .DBG_STATE(st_l)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_w4 (
        .CLK(clk), .RST(rst), .DIN(din_4), .DIN_VLD(vld_4), .DIN_RDY(rdy_4),
        .OUT(out_4), .OUT_VLD(ov_4), .FRAME_START(fs_4), .BUSY(busy_4), .DBG_STATE(st_4)
    );

    int tests = 0;
    int fails = 0;
    // Entries are {frame_start, bit}, in transmission order.
    logic [1:0] exp_m[$];
    logic [1:0] exp_l[$];
    logic [1:0] exp_4[$];
    int run_len = 0;
    int last_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic mon_step(input string tag, input logic ov, input logic ob, input logic fs,
                            input logic [1:0] e, input logic have);
        if (ov === 1'b1) begin
            if (!have) begin
                tests++;
                fails++;
                $display("FAIL %s_unexpected_bit: got bit %0b, expected no data", tag, ob);
            end else begin
                check({tag, "_bit"}, ob, e[0]);
                check({tag, "_frame_start"}, fs, e[1]);
            end
        end else if (!rst) begin
            check({tag, "_idle_out"}, ob, 1'b0);
            check({tag, "_idle_fs"}, fs, 1'b0);
        end
    endtask

    always @(negedge clk) begin : mon_m
        logic [1:0] e;
        logic have;
        have = (ov_m === 1'b1) && (exp_m.size() != 0);
        e = have ? exp_m.pop_front() : 2'b00;
        mon_step("m", ov_m, out_m, fs_m, e, have);
        if (ov_m === 1'b1) begin
            run_len++;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    always @(negedge clk) begin : mon_l
        logic [1:0] e;
        logic have;
        have = (ov_l === 1'b1) && (exp_l.size() != 0);
        e = have ? exp_l.pop_front() : 2'b00;
        mon_step("l", ov_l, out_l, fs_l, e, have);
    end

    always @(negedge clk) begin : mon_4
        logic [1:0] e;
        logic have;
        have = (ov_4 === 1'b1) && (exp_4.size() != 0);
        e = have ? exp_4.pop_front() : 2'b00;
        mon_step("w4", ov_4, out_4, fs_4, e, have);
    end

    // Drive and sample just after the falling edge, clear of both monitors and the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int d);
        case (d)
            0: return rdy_m;
            1: return rdy_l;
            default: return rdy_4;
        endcase
    endfunction

    // Presents a word and waits for DIN_RDY; leaves DIN_VLD high so callers can stream.
    // bits holds the expected OUT sequence, first-transmitted bit in the top position.
    task automatic send(input int d, input logic [7:0] w, input logic [7:0] bits, output int waits);
        int nb;
        nb = (d == 2) ? 4 : 8;
        waits = 0;
        case (d)
            0: begin din_m = w; vld_m = 1'b1; end
            1: begin din_l = w; vld_l = 1'b1; end
            default: begin din_4 = w[3:0]; vld_4 = 1'b1; end
        endcase
        while (!rdy_of(d) && waits < 40) begin
            tick();
            waits++;
        end
        if (!rdy_of(d)) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: DIN_RDY stayed 0 for %0d cycles on dut %0d, expected 1", waits, d);
        end else begin
            for (int i = nb - 1; i >= 0; i--) begin
                case (d)
                    0: exp_m.push_back({1'(i == nb - 1), bits[i]});
                    1: exp_l.push_back({1'(i == nb - 1), bits[i]});
                    default: exp_4.push_back({1'(i == nb - 1), bits[i]});
                endcase
            end
        end
        tick();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((busy_m || ov_m || busy_l || ov_l || busy_4 || ov_4) && k < 80) begin
            tick();
            k++;
        end
        tick();
        check(name, busy_m | busy_l | busy_4, 1'b0);
    endtask

    initial begin : stim
        int w;
        rst = 1'b1;
        din_m = '0; din_l = '0; din_4 = '0;
        vld_m = 1'b0; vld_l = 1'b0; vld_4 = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_held_din_rdy", rdy_m, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_din_rdy", rdy_m, 1'b1);
        check("rst_out", out_m, 1'b0);
        check("rst_out_vld", ov_m, 1'b0);
        check("rst_frame_start", fs_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_state", st_m, 1'b0);
        check("rst_w4_din_rdy", rdy_4, 1'b1);

        // Single word B8, MSB first: 1,0,1,1,1,0,0,0
        send(0, 8'hB8, 8'b10111000, w);
        vld_m = 1'b0;
        check("single_latency_vld", ov_m, 1'b1);
        check("single_latency_fs", fs_m, 1'b1);
        check("single_busy", busy_m, 1'b1);
        check("single_state", st_m, 1'b1);
        repeat (7) tick();
        check("single_last_vld", ov_m, 1'b1);
        check("single_last_fs", fs_m, 1'b0);
        tick();
        check("single_end_vld", ov_m, 1'b0);
        check("single_end_out", out_m, 1'b0);
        check("single_end_busy", busy_m, 1'b0);
        check("single_end_rdy", rdy_m, 1'b1);
        check("single_run_len", last_run, 8);

        // Streaming A5, 3C, FF with DIN_VLD held high
        send(0, 8'hA5, 8'b10100101, w);
        check("stream_first_wait", w, 0);
        send(0, 8'h3C, 8'b00111100, w);
        check("stream_hold_wait", w, 0);
        check("stream_hold_full_rdy", rdy_m, 1'b0);
        send(0, 8'hFF, 8'b11111111, w);
        check("backpressure_wait", w, 7);
        vld_m = 1'b0;
        drain("stream_drain");
        check("stream_run_len", last_run, 24);

        // Reset mid-word: 3 bits of F0 out, 0F in HOLD
        send(0, 8'hF0, 8'b11110000, w);
        send(0, 8'h0F, 8'b00001111, w);
        vld_m = 1'b0;
        tick();
        rst = 1'b1;
        exp_m.delete();
        tick();
        check("midrst_out_vld", ov_m, 1'b0);
        check("midrst_busy", busy_m, 1'b0);
        check("midrst_rdy_in_reset", rdy_m, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_rdy_after", rdy_m, 1'b1);
        send(0, 8'h81, 8'b10000001, w);
        vld_m = 1'b0;
        drain("midrst_drain");
        check("midrst_run_len", last_run, 8);

        // LSB first: 01 -> 1,0,0,0,0,0,0,0; width 4: A -> 0,1,0,1 then 3 -> 1,1,0,0
        send(1, 8'h01, 8'b10000000, w);
        vld_l = 1'b0;
        send(2, 8'h0A, 8'b00000101, w);
        send(2, 8'h03, 8'b00001100, w);
        check("w4_hold_wait", w, 0);
        vld_4 = 1'b0;
        drain("lsb_drain");

        check("exp_m_empty", exp_m.size(), 0);
        check("exp_l_empty", exp_l.size(), 0);
        check("exp_4_empty", exp_4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
